// File: rtl/rocc_cmd_queue_pkg.sv
// Package rocc_pkg: RoCC command field widths, the packed command struct
// and pack/unpack helpers shared by the command queue and its controller.
package rocc_pkg;

  localparam int FUNCT_W = 7;
  localparam int REG_W   = 5;
  localparam int OPC_W   = 7;
  localparam int XLEN    = 64;
  // funct + rs2/rs1/rd + xd/xs1/xs2 + opcode + two operands = 160 bits
  localparam int CMD_W   = FUNCT_W + 3 * REG_W + 3 + OPC_W + 2 * XLEN;

  // Field order matches the packed layout, MSB first
  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rs1;
    logic               xd;
    logic               xs1;
    logic               xs2;
    logic [REG_W-1:0]   rd;
    logic [OPC_W-1:0]   opcode;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
  } rocc_cmd_t;

  function automatic logic [CMD_W-1:0] pack_cmd(input rocc_cmd_t c);
    return c;
  endfunction

  function automatic rocc_cmd_t unpack_cmd(input logic [CMD_W-1:0] b);
    return rocc_cmd_t'(b);
  endfunction

endpackage

// File: rtl/rocc_cmd_queue_ctrl.sv
// rocc_queue_ctrl: read/write pointers and the maybe_full flag of the
// command queue; derives empty, full and occupancy. DEPTH is a power of two
// so the pointers wrap naturally.
module rocc_queue_ctrl #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic             deq,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic             maybe_full_reg, maybe_full_next;
  logic [PTR_W-1:0] ptr_diff;

  // Next pointer state; maybe_full only changes when exactly one side moves
  always_comb begin
    wptr_next       = enq ? wptr_reg + PTR_ONE : wptr_reg;
    rptr_next       = deq ? rptr_reg + PTR_ONE : rptr_reg;
    maybe_full_next = (enq != deq) ? enq : maybe_full_reg;
  end

  // Pointer/flag registers; reset discards all queued entries
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      maybe_full_reg <= 1'b0;
    end else begin
      wptr_reg       <= wptr_next;
      rptr_reg       <= rptr_next;
      maybe_full_reg <= maybe_full_next;
    end
  end

  assign wptr     = wptr_reg;
  assign rptr     = rptr_reg;
  assign empty    = (wptr_reg == rptr_reg) && !maybe_full_reg;
  assign full     = (wptr_reg == rptr_reg) &&  maybe_full_reg;
  assign ptr_diff = wptr_reg - rptr_reg;
  // Equal pointers mean 0 or DEPTH; the full flag supplies the extra MSB
  assign count    = CNT_W'({full, ptr_diff});

endmodule

// File: rtl/rocc_cmd_queue.sv
// rocc_cmd_queue: decoupling FIFO between the core RoCC command port and the
// accelerator. Holds the command storage and the output mux; pointer logic
// lives in rocc_queue_ctrl.
// Optional feature macro: ROCC_CMD_QUEUE_BYPASS_EN (empty-queue pass-through).
module rocc_cmd_queue
  import rocc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [REG_W-1:0]   in_rs2,
  input  logic [REG_W-1:0]   in_rs1,
  input  logic               in_xd,
  input  logic               in_xs1,
  input  logic               in_xs2,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [REG_W-1:0]   out_rs2,
  output logic [REG_W-1:0]   out_rs1,
  output logic               out_xd,
  output logic               out_xs1,
  output logic               out_xs2,
  output logic [REG_W-1:0]   out_rd,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [XLEN-1:0]    out_rs1_data,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [CNT_W-1:0]   count,
  input  logic               accel_busy,
  output logic               busy
);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             empty, full;
  logic             enq, deq;
  rocc_cmd_t        in_cmd;
  rocc_cmd_t        head;

  assign in_cmd = '{funct: in_funct, rs2: in_rs2, rs1: in_rs1,
                    xd: in_xd, xs1: in_xs1, xs2: in_xs2, rd: in_rd,
                    opcode: in_opcode, rs1_data: in_rs1_data,
                    rs2_data: in_rs2_data};

  assign in_ready = !full;

`ifdef ROCC_CMD_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming command; a same-cycle accept skips storage
  always_comb begin
    out_valid = !empty || in_valid;
    head      = empty ? in_cmd : unpack_cmd(mem[rptr]);
    enq       = in_valid && in_ready && !(empty && out_ready);
    deq       = !empty && out_ready;
  end
`else
  // Registered-only output: a command is visible the cycle after it is written
  always_comb begin
    out_valid = !empty;
    head      = unpack_cmd(mem[rptr]);
    enq       = in_valid && in_ready;
    deq       = !empty && out_ready;
  end
`endif

  // Command storage; not reset, stale entries are masked by the pointers
  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= pack_cmd(in_cmd);
  end

  rocc_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .enq   (enq),
    .deq   (deq),
    .wptr  (wptr),
    .rptr  (rptr),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign out_funct    = head.funct;
  assign out_rs2      = head.rs2;
  assign out_rs1      = head.rs1;
  assign out_xd       = head.xd;
  assign out_xs1      = head.xs1;
  assign out_xs2      = head.xs2;
  assign out_rd       = head.rd;
  assign out_opcode   = head.opcode;
  assign out_rs1_data = head.rs1_data;
  assign out_rs2_data = head.rs2_data;

  assign busy = (count != '0) || accel_busy;

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Scoreboard bench for rocc_cmd_queue (DEPTH=2). Stimulus pushes expected
// commands into exp_q; the monitor pops and compares on each out handshake.
module tb_rocc_cmd_queue;
  import rocc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic accel_busy = 1'b0;
  rocc_cmd_t cur = '0;

  logic               in_ready, out_valid;
  logic [FUNCT_W-1:0] out_funct;
  logic [REG_W-1:0]   out_rs2, out_rs1, out_rd;
  logic               out_xd, out_xs1, out_xs2;
  logic [OPC_W-1:0]   out_opcode;
  logic [XLEN-1:0]    out_rs1_data, out_rs2_data;
  logic [1:0]         count;
  logic               busy;

  int n_checks = 0;
  int n_pass   = 0;
  rocc_cmd_t exp_q[$];

  always #5 clk = ~clk;

  rocc_cmd_queue #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_funct(cur.funct), .in_rs2(cur.rs2), .in_rs1(cur.rs1), .in_xd(cur.xd),
    .in_xs1(cur.xs1), .in_xs2(cur.xs2), .in_rd(cur.rd), .in_opcode(cur.opcode),
    .in_rs1_data(cur.rs1_data), .in_rs2_data(cur.rs2_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_funct(out_funct),
    .out_rs2(out_rs2), .out_rs1(out_rs1), .out_xd(out_xd), .out_xs1(out_xs1),
    .out_xs2(out_xs2), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .count(count), .accel_busy(accel_busy), .busy(busy)
  );

  function automatic rocc_cmd_t mk(input logic [6:0] funct, input logic [63:0] d1,
                                   input logic [63:0] d2, input logic [4:0] rd,
                                   input logic xd);
    rocc_cmd_t c;
    c.funct = funct;          c.rs2 = rd + 5'd2;     c.rs1 = rd + 5'd1;
    c.xd = xd;                c.xs1 = 1'b1;          c.xs2 = d1[0];
    c.rd = rd;                c.opcode = 7'h0b;
    c.rs1_data = d1;          c.rs2_data = d2;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output must match the oldest expected command
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      rocc_cmd_t got;
      got = '{funct: out_funct, rs2: out_rs2, rs1: out_rs1, xd: out_xd,
              xs1: out_xs1, xs2: out_xs2, rd: out_rd, opcode: out_opcode,
              rs1_data: out_rs1_data, rs2_data: out_rs2_data};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL deq_unexpected: got rs1_data=%0h expected no output", got.rs1_data);
      end else begin
        rocc_cmd_t e;
        e = exp_q.pop_front();
        if (got === e) begin
          n_pass++;
          $display("deq rs1_data=%0h rs2_data=%0h rd=%0d ok", got.rs1_data, got.rs2_data, got.rd);
        end else begin
          $display("FAIL deq_cmd: got %h expected %h", got, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit done;
    rocc_cmd_t ca, cb, cc;
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    accel_busy = 1'b1; #1;
    check("busy_accel", busy, 1);
    accel_busy = 1'b0;

    // 1: single enqueue, visible next cycle
    ca = mk(7'd0, 64'd5, 64'd7, 5'd3, 1'b1);
    cur = ca; in_valid = 1'b1; exp_q.push_back(ca);
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_rs1_data", out_rs1_data, 5);
    check("t1_rs2_data", out_rs2_data, 7);
    check("t1_rd", out_rd, 3);
    check("t1_count", count, 1);
    check("t1_busy", busy, 1);

    // 2: fill, third command held
    cb = mk(7'd1, 64'hB, 64'hBB, 5'd4, 1'b0);
    cur = cb; in_valid = 1'b1; exp_q.push_back(cb);
    tick();
    check("t2_in_ready", in_ready, 0);
    check("t2_count", count, 2);
    cc = mk(7'd2, 64'hC, 64'hCC, 5'd5, 1'b1);
    cur = cc; exp_q.push_back(cc);
    tick();
    check("t2_held_count", count, 2);
    check("t2_held_in_ready", in_ready, 0);

    // 3: one dequeue frees a slot, then C enters
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_in_ready", in_ready, 1);
    check("t3_count", count, 1);
    check("t3_head_b", out_rs1_data, 64'hB);
    tick();
    in_valid = 1'b0;
    check("t3_c_count", count, 2);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("t3_drained_count", count, 0);
    check("t3_drained_valid", out_valid, 0);

    // 4: stream 1..5 with out_ready toggling
    for (int i = 1; i <= 5; i++) begin
      rocc_cmd_t c;
      c = mk(7'(i), 64'(i), 64'(i * 16), 5'(i), 1'b1);
      cur = c; in_valid = 1'b1; exp_q.push_back(c);
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        bit acc;
        out_ready = (i + k) % 2 == 1;
        acc = in_ready;
        tick();
        if (acc) done = 1;
      end
      if (!done) check("t4_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (count == 0) done = 1;
      else tick();
    end
    out_ready = 1'b0;
    check("t4_drain", done, 1);
    check("t4_sb_empty", exp_q.size(), 0);

    // 5: reset with two entries queued
    cur = mk(7'd9, 64'hD, 64'hDD, 5'd6, 1'b0); in_valid = 1'b1;
    tick();
    cur = mk(7'd10, 64'hE, 64'hEE, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t5_pre_count", count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_count", count, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    ca = mk(7'd11, 64'hF, 64'hFF, 5'd8, 1'b1);
    cur = ca; in_valid = 1'b1; exp_q.push_back(ca);
    tick();
    in_valid = 1'b0;
    check("t5_new_head", out_rs1_data, 64'hF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_count_after", count, 0);

    // 6: empty queue, in_valid and out_ready together
    cb = mk(7'd12, 64'h1234, 64'h5678, 5'd9, 1'b1);
    cur = cb; exp_q.push_back(cb);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
`ifdef ROCC_CMD_QUEUE_BYPASS_EN
    check("t6_bypass_valid", out_valid, 1);
    check("t6_bypass_count", count, 0);
    tick();
    in_valid = 1'b0;
    check("t6_bypass_count_next", count, 0);
    check("t6_bypass_valid_next", out_valid, 0);
`else
    check("t6_valid_same", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("t6_valid_next", out_valid, 1);
    check("t6_count_next", count, 1);
    tick();
    check("t6_count_after", count, 0);
`endif
    out_ready = 1'b0;
    tick();
    check("end_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
